lut_dump_capture_ctrl: RTL and testbench

//  Sequences port A of the DAC LUT dump buffer (8-bit x 4096 BRAM; CPU reads it on port B).

---
 rtl/lut_dump_pkg.sv | 15 +
 rtl/lut_dump_decim.sv | 39 +++
 rtl/lut_dump_capture_ctrl.sv | 168 ++++++++++++++++
 tb/tb_lut_dump_capture_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lut_dump_pkg.sv
// Shared types and default widths for the DAC LUT dump capture controller.
package lut_dump_pkg;

   localparam int unsigned ADDR_W_DEF  = 12;
   localparam int unsigned DATA_W_DEF  = 8;
   localparam int unsigned DECIM_W_DEF = 4;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StArmed   = 2'd1,
      StCapture = 2'd2,
      StDone    = 2'd3
   } state_e;

endpackage

// File: rtl/lut_dump_decim.sv
// Decimation counter: keeps one of every decim+1 valid samples while enabled.
module lut_dump_decim
   import lut_dump_pkg::*;
#(
   parameter int unsigned DECIM_W = DECIM_W_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr,
   input  logic               en,
   input  logic               data_valid,
   input  logic [DECIM_W-1:0] decim,
   output logic               accept
);

   localparam logic [DECIM_W-1:0] CntOne = DECIM_W'(1);

   logic [DECIM_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && data_valid) begin
         cnt_d = (cnt_q == decim) ? '0 : cnt_q + CntOne;
      end
   end

   assign accept = en & data_valid & (cnt_q == '0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/lut_dump_capture_ctrl.sv
// Port A sequencer for the DAC LUT dump buffer: arm, optional sync, decimated fixed-length write.
module lut_dump_capture_ctrl
   import lut_dump_pkg::*;
#(
   parameter int unsigned ADDR_W  = ADDR_W_DEF,
   parameter int unsigned DATA_W  = DATA_W_DEF,
   parameter int unsigned DECIM_W = DECIM_W_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               arm,
   input  logic               abort,
   input  logic               use_sync,
   input  logic [DECIM_W-1:0] decim,
   input  logic [ADDR_W-1:0]  len_m1,
   input  logic               sync_in,
   input  logic [DATA_W-1:0]  data_in,
   input  logic               data_valid,
   output logic               bram_en_a,
   output logic               bram_we,
   output logic [ADDR_W-1:0]  bram_addr,
   output logic [DATA_W-1:0]  bram_wr_data,
   output logic               busy,
   output logic               done,
   output logic [ADDR_W:0]    wr_count
);

   localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);
   localparam logic [ADDR_W:0]   CntOne  = (ADDR_W + 1)'(1);

   state_e              state_q, state_d;
   logic                arm_q;
   logic                use_sync_q, use_sync_d;
   logic [DECIM_W-1:0]  decim_q, decim_d;
   logic [ADDR_W-1:0]   len_m1_q, len_m1_d;
   logic [ADDR_W-1:0]   acc_idx_q, acc_idx_d;
   logic                last_q, last_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wr_data_q, wr_data_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [ADDR_W:0]     wr_count_q, wr_count_d;

   logic arm_edge, decim_clr, decim_en, accept;

   assign arm_edge = arm & ~arm_q;

   // The sync sample itself is word 0, so the counter is enabled on it while still ARMED.
   assign decim_en = ((state_q == StCapture) && !last_q) ||
                     ((state_q == StArmed) && use_sync_q && sync_in);

   lut_dump_decim #(
      .DECIM_W (DECIM_W)
   ) u_decim (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (decim_clr),
      .en         (decim_en),
      .data_valid (data_valid),
      .decim      (decim_q),
      .accept     (accept)
   );

   always_comb begin
      state_d    = state_q;
      use_sync_d = use_sync_q;
      decim_d    = decim_q;
      len_m1_d   = len_m1_q;
      acc_idx_d  = acc_idx_q;
      last_d     = last_q;
      we_d       = 1'b0;
      addr_d     = addr_q;
      wr_data_d  = wr_data_q;
      wr_count_d = wr_count_q;
      decim_clr  = 1'b0;

      if (accept) begin
         we_d      = 1'b1;
         wr_data_d = data_in;
         acc_idx_d = acc_idx_q + AddrOne;
         if (acc_idx_q == len_m1_q) begin
            last_d = 1'b1;
         end
      end

      if (we_q) begin
         addr_d     = addr_q + AddrOne;
         wr_count_d = wr_count_q + CntOne;
      end

      unique case (state_q)
         StIdle, StDone: begin
            if (arm_edge) begin
               state_d    = StArmed;
               use_sync_d = use_sync;
               decim_d    = decim;
               len_m1_d   = len_m1;
               acc_idx_d  = '0;
               last_d     = 1'b0;
               addr_d     = '0;
               wr_count_d = '0;
               decim_clr  = 1'b1;
            end
         end
         StArmed: begin
            if (!use_sync_q || accept) begin
               state_d = StCapture;
            end
         end
         StCapture: begin
            // last_q is set only in the write cycle of the final word.
            if (last_q) begin
               state_d = StDone;
            end
         end
      endcase

      if (abort) begin
         state_d = StIdle;
         we_d    = 1'b0;
      end

      busy_d = (state_d == StArmed) || (state_d == StCapture);
      done_d = (state_d == StDone);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         arm_q      <= 1'b0;
         use_sync_q <= 1'b0;
         decim_q    <= '0;
         len_m1_q   <= '0;
         acc_idx_q  <= '0;
         last_q     <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wr_data_q  <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         wr_count_q <= '0;
      end else begin
         state_q    <= state_d;
         arm_q      <= arm;
         use_sync_q <= use_sync_d;
         decim_q    <= decim_d;
         len_m1_q   <= len_m1_d;
         acc_idx_q  <= acc_idx_d;
         last_q     <= last_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wr_data_q  <= wr_data_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         wr_count_q <= wr_count_d;
      end
   end

   assign bram_en_a    = we_q;
   assign bram_we      = we_q;
   assign bram_addr    = addr_q;
   assign bram_wr_data = wr_data_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign wr_count     = wr_count_q;

endmodule

// File: tb/tb_lut_dump_capture_ctrl.sv
// Directed bench for lut_dump_capture_ctrl: logs every port A write and checks runs against hand values.
module tb_lut_dump_capture_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        arm, abort, use_sync, sync_in, data_valid;
   logic [3:0]  decim;
   logic [11:0] len_m1;
   logic [7:0]  data_in;
   logic        bram_en_a, bram_we, busy, done;
   logic [11:0] bram_addr;
   logic [7:0]  bram_wr_data;
   logic [12:0] wr_count;

   int total = 0;
   int bad   = 0;
   int n     = 0;
   int en_diff = 0;
   int base;
   logic [11:0] log_addr [0:8191];
   logic [7:0]  log_data [0:8191];

   always #5 clk = ~clk;

   lut_dump_capture_ctrl u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .arm          (arm),
      .abort        (abort),
      .use_sync     (use_sync),
      .decim        (decim),
      .len_m1       (len_m1),
      .sync_in      (sync_in),
      .data_in      (data_in),
      .data_valid   (data_valid),
      .bram_en_a    (bram_en_a),
      .bram_we      (bram_we),
      .bram_addr    (bram_addr),
      .bram_wr_data (bram_wr_data),
      .busy         (busy),
      .done         (done),
      .wr_count     (wr_count)
   );

   always @(negedge clk) begin
      if (bram_en_a !== bram_we) en_diff++;
      if (bram_we === 1'b1) begin
         if (n < 8192) begin
            log_addr[n] = bram_addr;
            log_data[n] = bram_wr_data;
         end
         n++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Writes since b must be cnt words at addr i with data (d0 + i*step) mod 256.
   task automatic check_run(input string tag, input int b, input int cnt, input int d0,
                            input int step);
      int errs = 0;
      check({tag, "_count"}, n - b, cnt);
      for (int i = 0; i < cnt && (b + i) < 8192; i++) begin
         if (log_addr[b + i] !== 12'(i)) errs++;
         if (log_data[b + i] !== 8'(d0 + i * step)) errs++;
      end
      check({tag, "_words"}, errs, 0);
   endtask

   task automatic do_arm();
      arm = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; arm = 1'b0; abort = 1'b0; use_sync = 1'b0; sync_in = 1'b0;
      data_valid = 1'b0; decim = '0; len_m1 = '0; data_in = '0;
      tick();
      tick();
      check("rst_en", bram_en_a, 0);
      check("rst_we", bram_we, 0);
      check("rst_addr", bram_addr, 0);
      check("rst_data", bram_wr_data, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_count", wr_count, 0);
      rst_n = 1'b1;
      tick();

      // 1: immediate start, no decimation, 8 words
      use_sync = 1'b0; decim = 4'd0; len_m1 = 12'd7; base = n;
      do_arm();
      check("t1_busy_armed", busy, 1);
      tick();
      check("t1_no_we_yet", bram_we, 0);
      for (int i = 0; i < 12; i++) begin
         data_in = 8'(8'h10 + i); data_valid = 1'b1;
         tick();
         if (i == 0) begin
            check("t1_first_we", bram_we, 1);
            check("t1_first_addr", bram_addr, 0);
            check("t1_first_data", bram_wr_data, 8'h10);
         end
      end
      data_valid = 1'b0;
      check_run("t1", base, 8, 8'h10, 1);
      check("t1_done", done, 1);
      check("t1_busy", busy, 0);
      check("t1_count", wr_count, 8);
      check("t1_addr_end", bram_addr, 8);

      // 2: wait for sync; only the sync sample onward is captured
      use_sync = 1'b1; decim = 4'd0; len_m1 = 12'd3; base = n;
      do_arm();
      for (int i = 0; i < 3; i++) begin
         data_in = 8'(8'h30 + i); data_valid = 1'b1;
         tick();
      end
      check("t2_busy_wait", busy, 1);
      check("t2_no_early_write", n - base, 0);
      data_in = 8'h33; sync_in = 1'b1;
      tick();
      for (int i = 1; i < 7; i++) begin
         data_in = 8'(8'h33 + i); sync_in = (i == 2);
         tick();
      end
      sync_in = 1'b0; data_valid = 1'b0;
      check_run("t2", base, 4, 8'h33, 1);
      check("t2_done", done, 1);

      // 3: decim=2 with periodic valid gaps
      use_sync = 1'b0; decim = 4'd2; len_m1 = 12'd3; base = n;
      do_arm();
      tick();
      begin
         int v = 0;
         for (int c = 0; c < 20; c++) begin
            if (c % 4 == 3) begin
               data_valid = 1'b0; data_in = 8'hEE;
            end else begin
               data_valid = 1'b1; data_in = 8'(v); v++;
            end
            tick();
         end
      end
      data_valid = 1'b0;
      check_run("t3", base, 4, 0, 3);
      check("t3_count", wr_count, 4);
      check("t3_done", done, 1);

      // 4: abort after 5 of 16 words, then restart
      decim = 4'd0; len_m1 = 12'd15; base = n;
      do_arm();
      tick();
      for (int i = 0; i < 5; i++) begin
         data_in = 8'(8'h40 + i); data_valid = 1'b1;
         tick();
      end
      abort = 1'b1; data_in = 8'h45;
      tick();
      check("t4_we_off", bram_we, 0);
      check("t4_busy", busy, 0);
      check("t4_done", done, 0);
      check("t4_count", wr_count, 5);
      data_in = 8'h46;
      tick();
      abort = 1'b0;
      tick();
      check_run("t4", base, 5, 8'h40, 1);
      len_m1 = 12'd1; base = n;
      do_arm();
      tick();
      for (int i = 0; i < 5; i++) begin
         data_in = 8'(8'h50 + i);
         tick();
      end
      check_run("t4b", base, 2, 8'h50, 1);
      check("t4b_done", done, 1);

      // 5: arm edge mid-capture ignored; re-arm from DONE; config latched at arm
      len_m1 = 12'd3; base = n;
      do_arm();
      tick();
      for (int i = 0; i < 8; i++) begin
         data_in = 8'(8'h60 + i); arm = (i == 1);
         tick();
      end
      arm = 1'b0;
      check_run("t5", base, 4, 8'h60, 1);
      check("t5_done", done, 1);
      check("t5_count", wr_count, 4);
      len_m1 = 12'd1; base = n;
      do_arm();
      check("t5_rearm_done", done, 0);
      check("t5_rearm_busy", busy, 1);
      check("t5_rearm_count", wr_count, 0);
      check("t5_rearm_addr", bram_addr, 0);
      len_m1 = 12'd7;
      tick();
      for (int i = 0; i < 6; i++) begin
         data_in = 8'(8'h70 + i);
         tick();
      end
      check_run("t5b", base, 2, 8'h70, 1);
      check("t5b_count", wr_count, 2);

      // 6: full 4096-word buffer, address wrap, then reset mid-capture
      len_m1 = 12'hFFF; base = n;
      do_arm();
      tick();
      for (int i = 0; i < 4099; i++) begin
         data_in = 8'(i);
         tick();
      end
      check_run("t6", base, 4096, 0, 1);
      check("t6_done", done, 1);
      check("t6_count", wr_count, 4096);
      check("t6_addr_wrap", bram_addr, 0);
      check("t6_busy", busy, 0);
      do_arm();
      tick();
      for (int i = 0; i < 20; i++) begin
         data_in = 8'(8'h80 + i);
         tick();
      end
      check("t6_mid_we", bram_we, 1);
      rst_n = 1'b0;
      tick();
      check("t6_rst_en", bram_en_a, 0);
      check("t6_rst_we", bram_we, 0);
      check("t6_rst_addr", bram_addr, 0);
      check("t6_rst_data", bram_wr_data, 0);
      check("t6_rst_busy", busy, 0);
      check("t6_rst_done", done, 0);
      check("t6_rst_count", wr_count, 0);
      rst_n = 1'b1; data_valid = 1'b0;
      tick();
      check("en_we_match", en_diff, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
